dec_result_reorder: RTL and testbench
=====================================

# dec_result_reorder

Downstream of the decision-tree inference pipeline: collects 1-bit classification results, which leave the traversal pipeline out of order because tree depth varies per sample. Holds them in a sliding window keyed by the 8-bit sample ID and releases them strictly in ID order over a valid/ready handshake to the result sink. Detects duplicate and out-of-window IDs and flags them stickily.

## Interface
- WINDOW, 64, reorder window depth in entries; power of two, 2..128
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- clr  in  1  synchronous clear; empties window, loads head from start_id
- start_id  in  8  head ID loaded on clr
- in_valid  in  1  result strobe from inference pipeline (no backpressure)
- in_id  in  8  sample ID of result
- in_bit  in  1  class result
- out_valid  out  1  head entry present
- out_ready  in  1  sink accepts
- out_id  out  8  ID of released result (= head ID)
- out_bit  out  1  released result
- pending  out  log2(WINDOW)+1  number of occupied entries
- err_dup  out  1  sticky: result for already-occupied slot dropped
- err_range  out  1  sticky: result outside window dropped

## Operation
- State: head[7:0]; occ[WINDOW-1:0]; res[WINDOW-1:0]; pending counter; two sticky flags.
- Slot of ID x = x[log2(WINDOW)-1:0]. Offset = (in_id - head) mod 256, 8-bit wrap arithmetic.
- Accept on in_valid: offset < WINDOW and occ[slot]==0 -> occ[slot]<=1, res[slot]<=in_bit.
- offset >= WINDOW -> drop, err_range<=1. offset < WINDOW and occ[slot]==1 -> drop, err_dup<=1. If both apply, only err_range is set.
- Release: out_valid = occ[head slot]; out_id = head; out_bit = res[head slot], all combinational from registers. On out_valid && out_ready: occ[head slot]<=0, head<=head+1 (255 wraps to 0).
- Simultaneous accept and release in one cycle: offset and occupancy are evaluated against pre-edge head/occ. An in_id equal to the head being released is a duplicate. An in_id with offset == WINDOW is out of range, even though the window advances that edge.
- pending: +1 on accept, -1 on release, unchanged when both or neither occur. Always equals popcount(occ).
- clr: occ<=0, pending<=0, head<=start_id, both errors cleared. clr has priority over same-cycle in_valid and release; the input is discarded and no error is set.
- Errors stay set until clr or reset.

## Timing
- Reset values: head=0, occ=0, res=0, pending=0, out_valid=0, out_id=0, out_bit=0, err_dup=0, err_range=0.
- Reset mid-operation discards all held results immediately (asynchronous).
- Accept-to-out_valid latency: 1 cycle. A result arriving at the head ID in cycle N gives out_valid=1 in cycle N+1.
- Throughput: one accept plus one release per cycle sustained.
- out_id and out_bit stay stable while out_valid && !out_ready. Sink may hold out_ready high continuously.
- Error flags assert the cycle after the offending in_valid.
- Full condition (pending==WINDOW) needs no special handling: any new in-window ID is necessarily a duplicate.

## Test plan
- In-order: after reset, IDs 0..9 with bits alternating 1,0, out_ready=1 -> out sequence ids 0..9 with the same bits, each 1 cycle after arrival, pending peaks at 1.
- Out-of-order: IDs 3,1,2,0 (bits 1,1,0,0), out_ready=1 -> no out_valid until ID 0 arrives, then ids 0,1,2,3 on 4 consecutive cycles with bits 0,1,0,1; pending 4->0.
- Wrap: clr with start_id=250, feed IDs 250..255, 0..5 in reverse order -> output 250..255, 0..5 in order; err_range stays 0.
- Errors (WINDOW=64, head=0): in_id=64 -> err_range=1, pending unchanged. in_id=5 twice -> err_dup=1, and the stored bit keeps its first value. clr -> both flags 0.
- Backpressure and simultaneity: hold out_ready=0 with IDs 0..63 accepted -> pending=64, out_id=0 stable. Raise out_ready while in_id=64 arrives -> err_range=1 and ID 0 is released. Next cycle in_id=64 -> accepted.
- Reset mid-stream: assert rst_n low with pending=7 -> all outputs return to reset values asynchronously. After release, ID 0 is required again before any output.

Source files
------------

// File: rtl/dec_result_reorder.sv
// Reorder buffer for out-of-order 1-bit classification results keyed by 8-bit sample ID.
// Results are parked in a sliding window and released strictly in ID order over valid/ready.
module dec_result_reorder #(
    parameter  int WINDOW = 64,
    localparam int AW     = $clog2(WINDOW)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic [7:0]    start_id,
    input  logic          in_valid,
    input  logic [7:0]    in_id,
    input  logic          in_bit,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_id,
    output logic          out_bit,
    output logic [AW:0]   pending,
    output logic          err_dup,
    output logic          err_range
);

    logic [7:0]        head_q, head_d;
    logic [WINDOW-1:0] occ_q, occ_d;
    logic [WINDOW-1:0] res_q, res_d;
    logic [AW:0]       pending_q, pending_d;
    logic              errDup_q, errDup_d;
    logic              errRange_q, errRange_d;

    logic [7:0]    offset;
    logic          inRange;
    logic          isDup;
    logic          doAccept;
    logic          doRelease;
    logic [AW-1:0] inSlot;
    logic [AW-1:0] headSlot;

    assign inSlot    = in_id[AW-1:0];
    assign headSlot  = head_q[AW-1:0];
    // Offset uses 8-bit wrap so a window straddling 255->0 is still contiguous.
    assign offset    = in_id - head_q;
    assign inRange   = {1'b0, offset} < 9'(WINDOW);
    assign isDup     = occ_q[inSlot];
    assign doAccept  = in_valid && inRange && !isDup;
    assign doRelease = occ_q[headSlot] && out_ready;

    assign out_valid = occ_q[headSlot];
    assign out_id    = head_q;
    assign out_bit   = res_q[headSlot];
    assign pending   = pending_q;
    assign err_dup   = errDup_q;
    assign err_range = errRange_q;

    always_comb begin
        head_d     = head_q;
        occ_d      = occ_q;
        res_d      = res_q;
        pending_d  = pending_q;
        errDup_d   = errDup_q;
        errRange_d = errRange_q;
        if (clr) begin
            head_d     = start_id;
            occ_d      = '0;
            pending_d  = '0;
            errDup_d   = 1'b0;
            errRange_d = 1'b0;
        end else begin
            // Accept and release never hit the same slot: one needs it empty, the other full.
            if (doRelease) begin
                occ_d[headSlot] = 1'b0;
                head_d          = head_q + 8'd1;
            end
            if (doAccept) begin
                occ_d[inSlot] = 1'b1;
                res_d[inSlot] = in_bit;
            end
            if (doAccept && !doRelease) begin
                pending_d = pending_q + 1'b1;
            end else if (!doAccept && doRelease) begin
                pending_d = pending_q - 1'b1;
            end
            if (in_valid && !inRange) begin
                errRange_d = 1'b1;
            end else if (in_valid && isDup) begin
                errDup_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q     <= '0;
            occ_q      <= '0;
            res_q      <= '0;
            pending_q  <= '0;
            errDup_q   <= 1'b0;
            errRange_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            occ_q      <= occ_d;
            res_q      <= res_d;
            pending_q  <= pending_d;
            errDup_q   <= errDup_d;
            errRange_q <= errRange_d;
        end
    end

endmodule

// File: tb/tb_dec_result_reorder.sv
// Directed self-checking bench for dec_result_reorder (WINDOW=64).
// Inputs change 1ns after the rising edge; outputs are sampled at that same point.
module tb_dec_result_reorder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] start_id = '0;
    logic       in_valid = 1'b0;
    logic [7:0] in_id = '0;
    logic       in_bit = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_id;
    logic       out_bit;
    logic [6:0] pending;
    logic       err_dup;
    logic       err_range;

    int errors = 0;
    int checks = 0;

    dec_result_reorder #(.WINDOW(64)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .start_id(start_id),
        .in_valid(in_valid), .in_id(in_id), .in_bit(in_bit),
        .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id), .out_bit(out_bit),
        .pending(pending), .err_dup(err_dup), .err_range(err_range)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doClear(input logic [7:0] sid);
        clr = 1'b1; start_id = sid; in_valid = 1'b0;
        tick();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got=%0d exp=0", out_valid); end
        checks++; if (out_id !== 8'd0) begin errors++; $display("[TB] FAIL reset_out_id got=%0d exp=0", out_id); end
        checks++; if (pending !== 7'd0) begin errors++; $display("[TB] FAIL reset_pending got=%0d exp=0", pending); end
        checks++; if ({err_dup, err_range} !== 2'b00) begin errors++; $display("[TB] FAIL reset_errs got=%b exp=00", {err_dup, err_range}); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_in_order();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_id = 8'(i); in_bit = (i % 2 == 0);
            tick();
            checks++; if (out_valid !== 1'b1 || out_id !== 8'(i) || out_bit !== (i % 2 == 0))
                begin errors++; $display("[TB] FAIL in_order_out[%0d] got v=%0d id=%0d b=%0d exp v=1 id=%0d b=%0d", i, out_valid, out_id, out_bit, i, (i % 2 == 0)); end
            checks++; if (pending !== 7'd1) begin errors++; $display("[TB] FAIL in_order_pending[%0d] got=%0d exp=1", i, pending); end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0 || pending !== 7'd0) begin errors++; $display("[TB] FAIL in_order_drain got v=%0d p=%0d exp v=0 p=0", out_valid, pending); end
    endtask

    task automatic test_out_of_order();
        logic [7:0] ids  [4] = '{8'd3, 8'd1, 8'd2, 8'd0};
        logic       bits [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic       expB [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        doClear(8'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_id = ids[i]; in_bit = bits[i];
            tick();
            if (i < 3) begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL ooo_early_valid[%0d] got=%0d exp=0", i, out_valid); end
            end
        end
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++; if (out_valid !== 1'b1 || out_id !== 8'(k) || out_bit !== expB[k] || pending !== 7'(4 - k))
                begin errors++; $display("[TB] FAIL ooo_out[%0d] got v=%0d id=%0d b=%0d p=%0d exp v=1 id=%0d b=%0d p=%0d", k, out_valid, out_id, out_bit, pending, k, expB[k], 4 - k); end
            tick();
        end
        checks++; if (pending !== 7'd0 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL ooo_drain got p=%0d v=%0d exp p=0 v=0", pending, out_valid); end
    endtask

    task automatic test_wrap();
        logic [7:0] id;
        doClear(8'd250);
        out_ready = 1'b1;
        for (int i = 11; i >= 0; i--) begin
            id = 8'd250 + 8'(i);
            in_valid = 1'b1; in_id = id; in_bit = id[0];
            tick();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 12; k++) begin
            id = 8'd250 + 8'(k);
            checks++; if (out_valid !== 1'b1 || out_id !== id || out_bit !== id[0])
                begin errors++; $display("[TB] FAIL wrap_out[%0d] got v=%0d id=%0d b=%0d exp v=1 id=%0d b=%0d", k, out_valid, out_id, out_bit, id, id[0]); end
            tick();
        end
        checks++; if (err_range !== 1'b0 || pending !== 7'd0) begin errors++; $display("[TB] FAIL wrap_final got er=%0d p=%0d exp er=0 p=0", err_range, pending); end
    endtask

    task automatic test_errors();
        doClear(8'd0);
        out_ready = 1'b0;
        in_valid = 1'b1; in_id = 8'd64; in_bit = 1'b1;
        tick();
        checks++; if (err_range !== 1'b1 || err_dup !== 1'b0 || pending !== 7'd0) begin errors++; $display("[TB] FAIL err_range_set got er=%0d ed=%0d p=%0d exp er=1 ed=0 p=0", err_range, err_dup, pending); end
        in_id = 8'd5; in_bit = 1'b1;
        tick();
        in_bit = 1'b0;
        tick();
        checks++; if (err_dup !== 1'b1 || pending !== 7'd1) begin errors++; $display("[TB] FAIL err_dup_set got ed=%0d p=%0d exp ed=1 p=1", err_dup, pending); end
        for (int i = 0; i < 5; i++) begin
            in_id = 8'(i); in_bit = 1'b0;
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (5) tick();
        checks++; if (out_valid !== 1'b1 || out_id !== 8'd5 || out_bit !== 1'b1) begin errors++; $display("[TB] FAIL err_dup_keep got v=%0d id=%0d b=%0d exp v=1 id=5 b=1", out_valid, out_id, out_bit); end
        out_ready = 1'b0;
        doClear(8'd0);
        checks++; if ({err_dup, err_range} !== 2'b00 || pending !== 7'd0) begin errors++; $display("[TB] FAIL err_clear got errs=%b p=%0d exp errs=00 p=0", {err_dup, err_range}, pending); end
    endtask

    task automatic test_back_to_back();
        doClear(8'd0);
        out_ready = 1'b0;
        for (int i = 0; i < 64; i++) begin
            in_valid = 1'b1; in_id = 8'(i); in_bit = i[0];
            tick();
        end
        in_valid = 1'b0;
        tick();
        checks++; if (pending !== 7'd64 || out_valid !== 1'b1 || out_id !== 8'd0) begin errors++; $display("[TB] FAIL full_state got p=%0d v=%0d id=%0d exp p=64 v=1 id=0", pending, out_valid, out_id); end
        out_ready = 1'b1; in_valid = 1'b1; in_id = 8'd64; in_bit = 1'b1;
        tick();
        checks++; if (err_range !== 1'b1 || out_id !== 8'd1 || pending !== 7'd63) begin errors++; $display("[TB] FAIL edge_range got er=%0d id=%0d p=%0d exp er=1 id=1 p=63", err_range, out_id, pending); end
        out_ready = 1'b0; in_id = 8'd64;
        tick();
        checks++; if (pending !== 7'd64 || out_id !== 8'd1 || err_dup !== 1'b0) begin errors++; $display("[TB] FAIL edge_accept got p=%0d id=%0d ed=%0d exp p=64 id=1 ed=0", pending, out_id, err_dup); end
        out_ready = 1'b1; in_id = 8'd1;
        tick();
        checks++; if (err_dup !== 1'b1 || pending !== 7'd63 || out_id !== 8'd2) begin errors++; $display("[TB] FAIL release_dup got ed=%0d p=%0d id=%0d exp ed=1 p=63 id=2", err_dup, pending, out_id); end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid_stream();
        doClear(8'd100);
        out_ready = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            in_valid = 1'b1; in_id = 8'(100 + i); in_bit = 1'b1;
            tick();
        end
        in_id = 8'd0;
        tick();
        in_valid = 1'b0;
        checks++; if (pending !== 7'd7 || err_range !== 1'b1) begin errors++; $display("[TB] FAIL pre_reset got p=%0d er=%0d exp p=7 er=1", pending, err_range); end
        rst_n = 1'b0;
        #1;
        checks++; if (pending !== 7'd0 || out_valid !== 1'b0 || out_id !== 8'd0 || out_bit !== 1'b0 || {err_dup, err_range} !== 2'b00)
            begin errors++; $display("[TB] FAIL async_reset got p=%0d v=%0d id=%0d b=%0d errs=%b exp all 0", pending, out_valid, out_id, out_bit, {err_dup, err_range}); end
        #1;
        rst_n = 1'b1;
        tick();
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1'b1; in_id = 8'(i); in_bit = 1'b1;
            tick();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_wait[%0d] got v=%0d exp v=0", i, out_valid); end
        end
        in_id = 8'd0; in_bit = 1'b0;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_id !== 8'd0 || out_bit !== 1'b0 || pending !== 7'd4) begin errors++; $display("[TB] FAIL post_reset_head got v=%0d id=%0d b=%0d p=%0d exp v=1 id=0 b=0 p=4", out_valid, out_id, out_bit, pending); end
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_out_of_order();
        test_wrap();
        test_errors();
        test_back_to_back();
        test_reset_mid_stream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
